// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant/select bundle between four requesters and the round-robin arbiter
// that owns the shared 4:1 mux select lines.
interface mux4_rr_arbiter_if;
  logic req0;
  logic req1;
  logic req2;
  logic req3;
  logic grant0;
  logic grant1;
  logic grant2;
  logic grant3;
  logic address0;
  logic address1;
  logic busy;

  modport master (
    output req0, req1, req2, req3,
    input  grant0, grant1, grant2, grant3, address0, address1, busy
  );

  modport slave (
    input  req0, req1, req2, req3,
    output grant0, grant1, grant2, grant3, address0, address1, busy
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter with a bounded hold time that drives the select lines of
// a shared 4:1 single-bit mux; grant and address are registered and coherent.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          reset,
  mux4_rr_arbiter_if.slave bus
);

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [0:0] {IDLE, GRANTED} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   addr_q, addr_d;
  logic               busy_q, busy_d;

  logic [N_REQ-1:0]   req;
  logic               others;
  logic               take;
  logic [IDX_W-1:0]   start;
  logic [IDX_W-1:0]   winner;

  assign req    = {bus.req3, bus.req2, bus.req1, bus.req0};
  assign others = |(req & ~(N_REQ'(1) << owner_q));

  // First asserted request scanning start, start+1, ... modulo 4.
  function automatic logic [IDX_W-1:0] pick(input logic [IDX_W-1:0] s,
                                            input logic [N_REQ-1:0] r);
    logic [IDX_W-1:0] idx;
    pick = s;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = s + IDX_W'(i);
      if (r[idx]) pick = idx;
    end
  endfunction

  assign winner = pick(start, req);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      grant_q <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    take    = 1'b0;
    start   = ptr_q;

    case (state_q)
      IDLE: begin
        if (|req) take = 1'b1;
      end
      GRANTED: begin
        if (!req[owner_q]) begin
          if (others) begin
            take  = 1'b1;
            start = owner_q + IDX_W'(1);
          end else begin
            // Release with nobody waiting: address keeps the last owner.
            state_d = IDLE;
            grant_d = '0;
            hold_d  = '0;
          end
        end else if (hold_q == CNT_W'(MAX_HOLD) && others) begin
          take  = 1'b1;
          start = owner_q + IDX_W'(1);
        end else if (hold_q != CNT_W'(MAX_HOLD)) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    // New owner: grant, address and pointer all move on the same edge.
    if (take) begin
      state_d = GRANTED;
      owner_d = winner;
      ptr_d   = winner + IDX_W'(1);
      hold_d  = CNT_W'(1);
      addr_d  = winner;
      grant_d = N_REQ'(1) << winner;
    end

    busy_d = |grant_d;
  end

  assign bus.grant0   = grant_q[0];
  assign bus.grant1   = grant_q[1];
  assign bus.grant2   = grant_q[2];
  assign bus.grant3   = grant_q[3];
  assign bus.address0 = addr_q[0];
  assign bus.address1 = addr_q[1];
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter with MAX_HOLD = 4: reset, single grant,
// rotation, handover, saturation, wrap-around and reset mid-grant.
module tb_mux4_rr_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mux4_rr_arbiter_if bus ();

  mux4_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  wire [3:0] g = {bus.grant3, bus.grant2, bus.grant1, bus.grant0};
  wire [1:0] a = {bus.address1, bus.address0};

  task automatic set_req(input logic [3:0] r);
    bus.req0 = r[0];
    bus.req1 = r[1];
    bus.req2 = r[2];
    bus.req3 = r[3];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Invariant monitor: one-hot grant and busy tracking the grants.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      checks++;
      if (bus.busy !== (|g) || $countones(g) > 1) begin
        errors++;
        $display("FAIL invariant: grant=%b busy=%b", g, bus.busy);
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    set_req(4'b0000);
    tick();
    tick();
    checks++;
    if (g !== 4'b0000 || a !== 2'b00 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: grant=%b addr=%b busy=%b want 0000/00/0", g, a, bus.busy);
    end
  endtask

  task automatic test_single();
    reset = 1'b0;
    set_req(4'b0100);
    tick();
    checks++;
    if (g !== 4'b0100 || a !== 2'b10 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: grant=%b addr=%b busy=%b want 0100/10/1", g, a, bus.busy);
    end
    set_req(4'b0000);
    tick();
    checks++;
    if (g !== 4'b0000 || a !== 2'b10 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_release: grant=%b addr=%b busy=%b want 0000/10/0", g, a, bus.busy);
    end
  endtask

  task automatic test_rotation();
    logic [1:0] exp_a;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    set_req(4'b1111);
    for (int c = 0; c < 20; c++) begin
      tick();
      exp_a = 2'((c / 4) % 4);
      checks++;
      if (g !== (4'b0001 << exp_a) || a !== exp_a) begin
        errors++;
        $display("FAIL rotation cycle %0d: grant=%b addr=%b want owner %0d", c, g, a, exp_a);
      end
    end
    set_req(4'b0000);
    tick();
    checks++;
    if (g !== 4'b0000 || a !== 2'b00) begin
      errors++;
      $display("FAIL rotation_idle: grant=%b addr=%b want 0000/00", g, a);
    end
  endtask

  task automatic test_handover();
    // pointer is 1 here, so req1 wins over req3
    set_req(4'b1010);
    tick();
    tick();
    checks++;
    if (g !== 4'b0010 || a !== 2'b01) begin
      errors++;
      $display("FAIL handover_owner1: grant=%b addr=%b want 0010/01", g, a);
    end
    set_req(4'b1000);
    tick();
    checks++;
    if (g !== 4'b1000 || a !== 2'b11 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL handover_owner3: grant=%b addr=%b busy=%b want 1000/11/1", g, a, bus.busy);
    end
    set_req(4'b0000);
    tick();
  endtask

  task automatic test_saturation();
    set_req(4'b0001);
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (g !== 4'b0001 || a !== 2'b00) begin
        errors++;
        $display("FAIL saturation_hold cycle %0d: grant=%b addr=%b want 0001/00", c, g, a);
      end
    end
    set_req(4'b0101);
    tick();
    checks++;
    if (g !== 4'b0100 || a !== 2'b10) begin
      errors++;
      $display("FAIL saturation_rotate: grant=%b addr=%b want 0100/10", g, a);
    end
    set_req(4'b0000);
    tick();
  endtask

  task automatic test_wraparound();
    // pointer is 3 after owner 2
    set_req(4'b1000);
    tick();
    checks++;
    if (g !== 4'b1000 || a !== 2'b11) begin
      errors++;
      $display("FAIL wrap_owner3: grant=%b addr=%b want 1000/11", g, a);
    end
    set_req(4'b0101);
    tick();
    checks++;
    if (g !== 4'b0001 || a !== 2'b00) begin
      errors++;
      $display("FAIL wrap_owner0: grant=%b addr=%b want 0001/00", g, a);
    end
    set_req(4'b0000);
    tick();
    // pointer should now be 1: req0 and req2 from idle must give 2
    set_req(4'b0101);
    tick();
    checks++;
    if (g !== 4'b0100 || a !== 2'b10) begin
      errors++;
      $display("FAIL wrap_ptr: grant=%b addr=%b want 0100/10", g, a);
    end
    set_req(4'b0000);
    tick();
  endtask

  task automatic test_reset_mid();
    // pointer is 3: scan 3,0,1 picks requester 1
    set_req(4'b0010);
    tick();
    checks++;
    if (g !== 4'b0010 || a !== 2'b01) begin
      errors++;
      $display("FAIL midreset_grant1: grant=%b addr=%b want 0010/01", g, a);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (g !== 4'b0000 || a !== 2'b00 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear: grant=%b addr=%b busy=%b want 0000/00/0", g, a, bus.busy);
    end
    reset = 1'b0;
    set_req(4'b0011);
    tick();
    checks++;
    if (g !== 4'b0001 || a !== 2'b00 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ptr0: grant=%b addr=%b busy=%b want 0001/00/1", g, a, bus.busy);
    end
    set_req(4'b0000);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    set_req(4'b0000);
    test_reset();
    test_single();
    test_rotation();
    test_handover();
    test_saturation();
    test_wraparound();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares the 4:1 single-bit multiplexer between four requesters. It registers a one-hot grant and drives the multiplexer's `address1:address0` selects from that grant, so the owning requester's `inN` reaches the shared `out`. A configurable hold limit bounds how long one requester can keep the multiplexer while others wait. The block sits directly in front of the multiplexer's select inputs; the multiplexer itself is unchanged.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive granted cycles before forced rotation when another requester is waiting; legal range 1..15.
- `clk`  input  1  sole clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high reset; sampled on rising `clk`.
- `req0`..`req3`  input  1 each  request lines; level-sensitive, held high for as long as access is wanted.
- `grant0`..`grant3`  output  1 each  registered one-hot grant; all low when idle.
- `address0`, `address1`  output  1 each  registered mux select, equal to the binary index of the current or most recent owner.
- `busy`  output  1  high exactly when one grant is high.

## Operation
- State: FSM {IDLE, GRANTED}; 2-bit `owner`; 2-bit priority pointer `ptr`; 4-bit `hold_cnt`.
- Reset values: state IDLE, all grants 0, `address1:address0` = 00, `busy` 0, `ptr` 0, `hold_cnt` 0.
- Selection function `pick(start)`: the first asserted `reqN` scanning `start`, `start+1`, ... modulo 4 (3 wraps to 0).
- IDLE:
  - No request: stay IDLE.
  - Any request: go to GRANTED with `owner` = `pick(ptr)` and `hold_cnt` = 1. The owner's grant is set, the address is set to `owner`, and `ptr` becomes `owner+1` mod 4.
- GRANTED, owner's request low (release): if another request is present, switch in the same edge to `pick(owner+1)` with `hold_cnt` = 1 and `ptr` = new owner+1. Otherwise go to IDLE: grants cleared, address unchanged.
- GRANTED, owner's request high, `hold_cnt` = `MAX_HOLD`, another request present: forced rotation to `pick(owner+1)`, same updates as a switch.
- GRANTED, owner's request high otherwise: keep owner. `hold_cnt` increments and saturates at `MAX_HOLD`. If a competitor appears after saturation, rotation happens on the next edge.
- Invariants:
  - At most one grant is high.
  - `busy` = OR of grants.
  - The address changes only on the same edge a new grant is issued.
  - A requester never receives two consecutive forced-rotation grants while another is waiting.

## Timing
- Request-to-grant latency: 1 cycle from IDLE. A request seen high at edge k produces a grant visible after edge k.
- Handover is bubble-free. When the owner drops its request before edge k and another requester is waiting, the new grant and address appear after edge k, with no idle cycle between owners.
- Forced rotation: an owner with continuous competition holds for exactly `MAX_HOLD` cycles.
- The grant and address are always coherent: both change on the same edge and both are registered, with no combinational path from `req` to outputs. Downstream samples the mux output one cycle after the grant appears, allowing for gate delay through the structural mux.
- Reset has priority over all events. Reset asserted mid-grant clears the grant and returns the address to 00 on that edge, regardless of requests. The first grant after reset deasserts uses `ptr` = 0.
- Simultaneous requests in IDLE: `ptr` alone decides the winner.
- Release and a new request on the same edge: the new requester is eligible immediately.

## Test plan
- Reset then single request: hold `reset`=1 for 2 cycles, then drop it and assert `req2`=1 → one cycle later `grant2`=1, address=10, `busy`=1. Drop `req2` → next cycle all grants 0, `busy`=0, address stays 10.
- Simultaneous requests after reset: `req0`..`req3`=1111 held, `MAX_HOLD`=4 → owners 0,1,2,3,0 in that order, each held exactly 4 cycles, addresses 00,01,10,11,00, no gap cycles.
- Early release handover: `req1` and `req3` high, owner 1. Drop `req1` after 2 cycles → `grant3` on the next edge, address 11, no cycle with `busy`=0.
- Saturation then competition: `req0` alone for 10 cycles (`hold_cnt` saturates at 4), then `req2` rises → `grant2` one cycle after `req2` is first sampled.
- Wrap-around: owner 3 releases while `req0` and `req2` are high → `grant0` (scan 0,1,2), then `ptr`=1.
- Reset mid-operation: assert `reset` while `grant1` is high with `req1` still high → next cycle grants 0, address 00. After release, with `req1` and `req0` both high, `grant0` wins.
